// File: rtl/risc_control_fsm.sv
// Multi-cycle control unit for the 32-bit RISC datapath. It steps each instruction through
// IF/ID/EX/MEM/WB and decodes every datapath strobe from the registered state and irout.
module risc_control_fsm #(
   parameter logic [3:0] ADD_FUNC = 4'b0000,
   parameter logic [5:0] HALT_OP  = 6'h3F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] irout,
   output logic        readim,
   output logic        ldir,
   output logic        ldnpc,
   output logic        ldA,
   output logic        ldB,
   output logic        ldimm,
   output logic        aluen,
   output logic        ldaluout,
   output logic        alusel1,
   output logic        alusel2,
   output logic [3:0]  alufunc,
   output logic [1:0]  opcond,
   output logic        seldest,
   output logic        regwrite,
   output logic        writedmem,
   output logic        readdmem,
   output logic        ldlmd,
   output logic        selwb,
   output logic        branch,
   output logic        ldpc,
   output logic        halted,
   output logic [2:0]  state,
   output logic [31:0] instr_count
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   logic [2:0] cur_state;
   logic [2:0] nxt_state;
   logic [5:0] opcode;
   logic       is_halt;
   logic       is_ralu;
   logic       is_ialu;
   logic       is_alu;
   logic       is_ld;
   logic       is_st;
   logic       is_br;
   logic       is_cbr;
   logic       unused_irout;

   // Opcode classes; HALT_OP takes priority so a parameter override cannot alias two classes.
   assign opcode  = irout[31:26];
   assign is_halt = (opcode == HALT_OP);
   assign is_ralu = !is_halt && (opcode == 6'b000000);
   assign is_ialu = !is_halt && (opcode[5:4] == 2'b01);
   assign is_alu  = is_ralu || is_ialu;
   assign is_ld   = !is_halt && (opcode == 6'b100000);
   assign is_st   = !is_halt && (opcode == 6'b100001);
   assign is_br   = !is_halt && (opcode == 6'b110000);
   assign is_cbr  = !is_halt && (opcode[5:2] == 4'b1100) && (opcode[1:0] != 2'b00);

   // Register indices and the branch offset are consumed by the datapath, not here.
   assign unused_irout = ^irout[25:4];

   assign state = cur_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= S_IF;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = S_IF;
      case (cur_state)
         S_IF: nxt_state = S_ID;
         S_ID: begin
            if (is_halt) begin
               nxt_state = S_HALT;
            end else if (is_br || is_cbr || is_alu || is_ld || is_st) begin
               nxt_state = S_EX;
            end else begin
               nxt_state = S_WB;
            end
         end
         S_EX: begin
            if (is_br) begin
               nxt_state = S_IF;
            end else if (is_alu) begin
               nxt_state = S_WB;
            end else begin
               nxt_state = S_MEM;
            end
         end
         S_MEM: nxt_state = is_ld ? S_WB : S_IF;
         S_WB: nxt_state = S_IF;
         S_HALT: nxt_state = S_HALT;
         default: nxt_state = S_IF;
      endcase
   end

   // Every output is forced low while reset is held, even though cur_state already reads IF.
   always_comb begin
      readim    = 1'b0;
      ldir      = 1'b0;
      ldnpc     = 1'b0;
      ldA       = 1'b0;
      ldB       = 1'b0;
      ldimm     = 1'b0;
      aluen     = 1'b0;
      ldaluout  = 1'b0;
      alusel1   = 1'b0;
      alusel2   = 1'b0;
      alufunc   = 4'b0000;
      opcond    = 2'b00;
      seldest   = 1'b0;
      regwrite  = 1'b0;
      writedmem = 1'b0;
      readdmem  = 1'b0;
      ldlmd     = 1'b0;
      selwb     = 1'b0;
      branch    = 1'b0;
      ldpc      = 1'b0;
      halted    = 1'b0;
      if (!reset) begin
         case (cur_state)
            S_IF: begin
               readim = 1'b1;
               ldir   = 1'b1;
               ldnpc  = 1'b1;
               ldimm  = 1'b1;
            end
            S_ID: begin
               ldA = 1'b1;
               ldB = 1'b1;
            end
            S_EX: begin
               if (is_br) begin
                  branch = 1'b1;
                  ldpc   = 1'b1;
               end else begin
                  aluen    = 1'b1;
                  ldaluout = 1'b1;
                  if (is_ralu) begin
                     alusel1 = 1'b1;
                     alufunc = irout[3:0];
                  end else if (is_ialu) begin
                     alusel1 = 1'b1;
                     alusel2 = 1'b1;
                     alufunc = irout[29:26];
                  end else if (is_ld || is_st) begin
                     alusel1 = 1'b1;
                     alusel2 = 1'b1;
                     alufunc = ADD_FUNC;
                  end else begin
                     // Conditional branch target: NPC + imm.
                     alusel2 = 1'b1;
                     alufunc = ADD_FUNC;
                  end
               end
            end
            S_MEM: begin
               if (is_ld) begin
                  readdmem = 1'b1;
                  ldlmd    = 1'b1;
               end else if (is_st) begin
                  writedmem = 1'b1;
                  ldpc      = 1'b1;
               end else begin
                  opcond = irout[27:26];
                  ldpc   = 1'b1;
               end
            end
            S_WB: begin
               ldpc = 1'b1;
               if (is_alu) begin
                  regwrite = 1'b1;
                  selwb    = 1'b1;
                  seldest  = is_ialu;
               end else if (is_ld) begin
                  regwrite = 1'b1;
                  seldest  = 1'b1;
               end
            end
            S_HALT: halted = 1'b1;
            default: begin
               halted = 1'b0;
            end
         endcase
      end
   end

   // Always assigned (adding zero when idle) so the register keeps whatever value it last held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_count <= 32'd0;
      end else begin
         instr_count <= instr_count + {31'd0, ldpc};
      end
   end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Bench for risc_control_fsm: a per-cycle reference model fills an expected queue and a
// negedge monitor compares every observed output vector against it.
`timescale 1ns/1ps
module tb_risc_control_fsm;

   localparam logic [3:0] ADD_FUNC = 4'b0000;
   localparam logic [5:0] HALT_OP  = 6'h3F;
   localparam int W = 60;

   typedef struct packed {
      logic        readim, ldir, ldnpc, lda, ldb, ldimm, aluen, ldaluout, alusel1, alusel2;
      logic [3:0]  alufunc;
      logic [1:0]  opcond;
      logic        seldest, regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted;
      logic [2:0]  state;
      logic [31:0] count;
   } obs_t;

   typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_CBR, C_HALT, C_NOP} cls_e;
   typedef enum int {P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5} phase_e;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] irout;
   logic        readim, ldir, ldnpc, ldA, ldB, ldimm, aluen, ldaluout, alusel1, alusel2;
   logic [3:0]  alufunc;
   logic [1:0]  opcond;
   logic        seldest, regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted;
   logic [2:0]  state;
   logic [31:0] instr_count;

   obs_t        act;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_want;
   logic [31:0] model_cnt;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   risc_control_fsm #(.ADD_FUNC(ADD_FUNC), .HALT_OP(HALT_OP)) dut (
      .clk(clk), .reset(reset), .irout(irout),
      .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldA(ldA), .ldB(ldB), .ldimm(ldimm),
      .aluen(aluen), .ldaluout(ldaluout), .alusel1(alusel1), .alusel2(alusel2),
      .alufunc(alufunc), .opcond(opcond), .seldest(seldest), .regwrite(regwrite),
      .writedmem(writedmem), .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb),
      .branch(branch), .ldpc(ldpc), .halted(halted), .state(state), .instr_count(instr_count)
   );

   assign act = {readim, ldir, ldnpc, ldA, ldB, ldimm, aluen, ldaluout, alusel1, alusel2,
                 alufunc, opcond, seldest, regwrite, writedmem, readdmem, ldlmd, selwb,
                 branch, ldpc, halted, state, instr_count};

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic cls_e classify(input logic [31:0] ir);
      int op;
      op = int'(ir[31:26]);
      if (op == int'(HALT_OP)) return C_HALT;
      if (op == 0) return C_R;
      if (op >= 16 && op <= 31) return C_I;
      if (op == 32) return C_LD;
      if (op == 33) return C_ST;
      if (op == 48) return C_BR;
      if (op >= 49 && op <= 51) return C_CBR;
      return C_NOP;
   endfunction

   // What the control unit should present in one phase of one instruction.
   function automatic obs_t expect_cycle(input cls_e c, input phase_e p, input logic [31:0] ir,
                                         input logic [31:0] cnt);
      obs_t o;
      o = '0;
      o.state = 3'(int'(p));
      o.count = cnt;
      case (p)
         P_IF: begin o.readim = 1'b1; o.ldir = 1'b1; o.ldnpc = 1'b1; o.ldimm = 1'b1; end
         P_ID: begin o.lda = 1'b1; o.ldb = 1'b1; end
         P_EX: begin
            if (c == C_BR) begin
               o.branch = 1'b1; o.ldpc = 1'b1;
            end else begin
               o.aluen = 1'b1; o.ldaluout = 1'b1;
               if (c == C_R) begin o.alusel1 = 1'b1; o.alufunc = ir[3:0]; end
               else if (c == C_I) begin o.alusel1 = 1'b1; o.alusel2 = 1'b1; o.alufunc = ir[29:26]; end
               else if (c == C_LD || c == C_ST) begin o.alusel1 = 1'b1; o.alusel2 = 1'b1; o.alufunc = ADD_FUNC; end
               else begin o.alusel2 = 1'b1; o.alufunc = ADD_FUNC; end
            end
         end
         P_MEM: begin
            if (c == C_LD) begin o.readdmem = 1'b1; o.ldlmd = 1'b1; end
            else if (c == C_ST) begin o.writedmem = 1'b1; o.ldpc = 1'b1; end
            else begin o.opcond = ir[27:26]; o.ldpc = 1'b1; end
         end
         P_WB: begin
            o.ldpc = 1'b1;
            if (c == C_R) begin o.regwrite = 1'b1; o.selwb = 1'b1; end
            else if (c == C_I) begin o.regwrite = 1'b1; o.selwb = 1'b1; o.seldest = 1'b1; end
            else if (c == C_LD) begin o.regwrite = 1'b1; o.seldest = 1'b1; end
         end
         default: o.halted = 1'b1;
      endcase
      return o;
   endfunction

   task automatic expect_instr(input logic [31:0] ir, input int halt_cycles, output int ncyc);
      cls_e   c;
      phase_e ph[$];
      obs_t   o;
      c = classify(ir);
      ph.push_back(P_IF);
      ph.push_back(P_ID);
      case (c)
         C_R, C_I: begin ph.push_back(P_EX); ph.push_back(P_WB); end
         C_LD: begin ph.push_back(P_EX); ph.push_back(P_MEM); ph.push_back(P_WB); end
         C_ST, C_CBR: begin ph.push_back(P_EX); ph.push_back(P_MEM); end
         C_BR: ph.push_back(P_EX);
         C_HALT: for (int k = 0; k < halt_cycles; k++) ph.push_back(P_HALT);
         default: ph.push_back(P_WB);
      endcase
      foreach (ph[i]) begin
         o = expect_cycle(c, ph[i], ir, model_cnt);
         exp_q.push_back(o);
         if (o.ldpc) model_cnt = model_cnt + 32'd1;
      end
      ncyc = ph.size();
   endtask

   // Called just after a rising edge with the DUT in IF.
   task automatic run_instr(input logic [31:0] ir);
      int n;
      irout = ir;
      expect_instr(ir, 0, n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  op;
      logic [31:0] ir;
      case ($urandom_range(0, 6))
         0: op = 6'h00;
         1: op = 6'h10 + 6'($urandom_range(0, 15));
         2: op = 6'h20;
         3: op = 6'h21;
         4: op = 6'h30;
         5: op = 6'h31 + 6'($urandom_range(0, 2));
         default: begin
            case ($urandom_range(0, 2))
               0: op = 6'($urandom_range(1, 15));
               1: op = 6'($urandom_range(34, 47));
               default: op = 6'($urandom_range(52, 62));
            endcase
         end
      endcase
      ir = $urandom;
      ir[31:26] = op;
      return ir;
   endfunction

   always @(negedge clk) begin
      if (!reset && exp_q.size() > 0) begin
         mon_want = exp_q.pop_front();
         check("cycle_outputs", act, mon_want);
      end
   end

   initial begin
      int n;
      logic [31:0] cnt_before;
      reset = 1'b1;
      irout = 32'h0;
      model_cnt = 32'd0;
      #1 check("reset_outputs_zero", act, '0);
      repeat (2) @(posedge clk);
      #1 check("reset_held_zero", act, '0);
      #1 reset = 1'b0;

      // Directed: R-ALU, I-ALU, LD, ST, BZ, BR, NOP.
      cnt_before = model_cnt;
      run_instr(32'h0000_5802);
      check("ralu_count_plus1", {28'd0, instr_count}, {28'd0, cnt_before + 32'd1});
      run_instr(32'h4400_1234);
      run_instr(32'h8043_0010);
      run_instr(32'h8443_0010);
      run_instr(32'hCC00_0004);
      run_instr(32'hC000_0040);
      run_instr(32'h0800_0000);
      check("directed_count", {28'd0, instr_count}, {28'd0, 32'd7});

      // Reset while in EX of an I-ALU instruction.
      irout = 32'h4800_0001;
      expect_instr(irout, 0, n);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      repeat (2) @(posedge clk);
      #1 check("pre_reset_in_ex", {57'd0, state}, {57'd0, 3'd2});
      reset = 1'b1;
      #1 check("midex_reset_zero", act, '0);
      check("midex_state_if", {57'd0, state}, '0);
      check("midex_count_zero", {28'd0, instr_count}, '0);
      model_cnt = 32'd0;
      @(posedge clk);
      #2 reset = 1'b0;
      run_instr(32'h0000_5802);
      check("after_reset_count", {28'd0, instr_count}, {28'd0, 32'd1});

      for (int i = 0; i < 40; i++) run_instr(rand_instr());

      // Counter wrap: hold a forced all-ones value across a non-retiring edge, then run a NOP.
      irout = 32'h0800_0000;
      force dut.instr_count = 32'hFFFF_FFFF;
      model_cnt = 32'hFFFF_FFFF;
      expect_instr(irout, 0, n);
      @(posedge clk);
      #1 release dut.instr_count;
      repeat (n - 1) @(posedge clk);
      #1 check("wrap_count_zero", {28'd0, instr_count}, '0);
      run_instr(32'h0000_5802);

      // HALT: halted for 100 cycles, no strobes, count frozen.
      irout = {HALT_OP, 26'h155_5555};
      cnt_before = model_cnt;
      expect_instr(irout, 100, n);
      repeat (n) @(posedge clk);
      #1 check("halt_count_frozen", {28'd0, instr_count}, {28'd0, cnt_before});
      check("halt_still_halted", {59'd0, halted}, {59'd0, 1'b1});

      reset = 1'b1;
      #1 check("halt_reset_zero", act, '0);
      model_cnt = 32'd0;
      @(posedge clk);
      #2 reset = 1'b0;
      run_instr(32'h0400_0000);
      check("post_halt_nop_count", {28'd0, instr_count}, {28'd0, 32'd1});
      check("queue_drained", W'(exp_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
